// File: rtl/masked_sbox_layer_serial.sv
// Nibble-serial driver for a two-share, 1-cycle-latency S-box core: streams a masked
// state through the core one nibble pair per cycle and reassembles the masked result.
module masked_sbox_layer_serial #(
   parameter int NIBBLES = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   in_share0,
   input  logic [4*NIBBLES-1:0]   in_share1,
   output logic [3:0]             sbox_a0,
   output logic [3:0]             sbox_a1,
   input  logic [3:0]             sbox_x0,
   input  logic [3:0]             sbox_x1,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   out_share0,
   output logic [4*NIBBLES-1:0]   out_share1,
   output logic                   busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES + 1);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   logic [CW-1:0]   cnt_r;
   logic [W-1:0]    src0_r;
   logic [W-1:0]    src1_r;
   logic [W-1:0]    dst0_r;
   logic [W-1:0]    dst1_r;
   logic            issue_s;

   // Sequencer: load, issue/capture shift chains and handshake flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         src0_r    <= '0;
         src1_r    <= '0;
         dst0_r    <= '0;
         dst1_r    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  src0_r   <= in_share0;
                  src1_r   <= in_share1;
                  cnt_r    <= '0;
                  state_r  <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end else begin
                  state_r  <= IDLE;
               end
            end
            RUN: begin
               // The core output seen at cnt==0 is whatever it held before; skip it.
               if (cnt_r != '0) begin
                  dst0_r <= {sbox_x0, dst0_r[W-1:4]};
                  dst1_r <= {sbox_x1, dst1_r[W-1:4]};
               end else begin
                  dst0_r <= dst0_r;
                  dst1_r <= dst1_r;
               end
               if (cnt_r == LAST) begin
                  src0_r    <= '0;
                  src1_r    <= '0;
                  cnt_r     <= '0;
                  state_r   <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  src0_r    <= {4'h0, src0_r[W-1:4]};
                  src1_r    <= {4'h0, src1_r[W-1:4]};
                  cnt_r     <= cnt_r + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end else begin
                  state_r   <= DONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               cnt_r     <= '0;
               src0_r    <= '0;
               src1_r    <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Core operands are forced to zero whenever no nibble is being issued.
   always_comb begin
      issue_s = (state_r == RUN) && (cnt_r < LAST);
      if (issue_s) begin
         sbox_a0 = src0_r[3:0];
         sbox_a1 = src1_r[3:0];
      end else begin
         sbox_a0 = 4'h0;
         sbox_a1 = 4'h0;
      end
   end

   assign out_share0 = dst0_r;
   assign out_share1 = dst1_r;

endmodule

// File: tb/tb_masked_sbox_layer_serial.sv
// Self-checking bench: stub and masked inverse-S-box cores, table vectors, random states,
// backpressure, mid-run reset and stale-core-output scenarios.
module tb_masked_sbox_layer_serial;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [63:0] in_share0 = 64'h0;
   logic [63:0] in_share1 = 64'h0;
   logic        in_ready, out_valid, busy;
   logic [3:0]  sbox_a0, sbox_a1;
   logic [3:0]  core_x0 = 4'h0;
   logic [3:0]  core_x1 = 4'h0;
   logic [3:0]  core_r = 4'h0;
   logic [63:0] out_share0, out_share1;
   bit          real_core = 1'b0;
   bit          poison = 1'b0;

   int checks = 0;
   int errors = 0;

   masked_sbox_layer_serial #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_share0(in_share0), .in_share1(in_share1),
      .sbox_a0(sbox_a0), .sbox_a1(sbox_a1),
      .sbox_x0(core_x0), .sbox_x1(core_x1),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_share0(out_share0), .out_share1(out_share1),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] sbox_inv(input logic [3:0] v);
      logic [63:0] t;
      t = 64'h A970364BD21C8FE5;
      return t[4*v +: 4];
   endfunction

   // PRESENT forward S-box; the golden inverse is found by searching it.
   function automatic logic [3:0] sbox_fwd(input logic [3:0] v);
      logic [63:0] t;
      t = 64'h 21748FE3DA09B65C;
      return t[4*v +: 4];
   endfunction

   always @(negedge clk) core_r <= 4'($urandom);

   // Core model: unreset register, stub or refreshed masked inverse S-box.
   always @(posedge clk) begin
      if (poison) begin
         core_x0 <= 4'hA;
         core_x1 <= 4'h3;
      end else if (real_core) begin
         core_x0 <= sbox_inv(sbox_a0 ^ sbox_a1) ^ core_r;
         core_x1 <= core_r;
      end else begin
         core_x0 <= sbox_a0 ^ 4'h5;
         core_x1 <= sbox_a1;
      end
   end

   function automatic logic [63:0] stub_ref(input logic [63:0] s);
      logic [63:0] r;
      for (int i = 0; i < N; i++) r[4*i +: 4] = s[4*i +: 4] ^ 4'h5;
      return r;
   endfunction

   function automatic logic [63:0] golden_inv(input logic [63:0] s);
      logic [63:0] r;
      r = 64'h0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < 16; j++)
            if (sbox_fwd(4'(j)) == s[4*i +: 4]) r[4*i +: 4] = 4'(j);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_txn(input logic [63:0] s0, input logic [63:0] s1, input int hold,
                          output logic [63:0] r0, output logic [63:0] r1, output int lat);
      int w;
      int bad;
      logic [63:0] sh0, sh1;
      logic [3:0] ea0, ea1;
      @(negedge clk);
      in_valid = 1'b1; in_share0 = s0; in_share1 = s1; out_ready = (hold == 0);
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0; r0 = 64'h0; r1 = 64'h0; lat = -1;
         return;
      end
      @(posedge clk);
      lat = 0; bad = 0;
      @(negedge clk);
      in_valid = 1'b0; poison = 1'b0;
      chk("busy_run", 64'(busy), 64'd1);
      chk("in_ready_run", 64'(in_ready), 64'd0);
      while (!out_valid && lat < 100) begin
         sh0 = s0 >> (4 * lat); sh1 = s1 >> (4 * lat);
         ea0 = (lat < N) ? sh0[3:0] : 4'h0;
         ea1 = (lat < N) ? sh1[3:0] : 4'h0;
         if (sbox_a0 !== ea0 || sbox_a1 !== ea1) bad++;
         @(posedge clk); lat++; @(negedge clk);
      end
      if (sbox_a0 !== 4'h0 || sbox_a1 !== 4'h0) bad++;
      chk("sbox_a_seq", 64'(bad), 64'd0);
      chk("latency", 64'(lat), 64'd17);
      r0 = out_share0; r1 = out_share1;
      if (hold > 0) begin
         bad = 0;
         for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_share0 = ~s0;
            @(posedge clk); @(negedge clk);
            if (out_share0 !== r0 || out_share1 !== r1 || out_valid !== 1'b1 || in_ready !== 1'b0)
               bad++;
         end
         chk("backpressure_hold", 64'(bad), 64'd0);
         in_valid = 1'b0; out_ready = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      chk("in_ready_back", 64'(in_ready), 64'd1);
      chk("out_valid_drop", 64'(out_valid), 64'd0);
   endtask

   typedef struct {
      logic [63:0] s0;
      logic [63:0] s1;
      int          hold;
      logic [63:0] e0;
      logic [63:0] e1;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic [63:0] r0, r1, s, m;
      int lat;

      vecs[0] = '{64'h0123456789ABCDEF, 64'h0, 0, 64'h54761032DCFE98BA, 64'h0};
      vecs[1] = '{64'h0, 64'hFEDCBA9876543210, 0, 64'h5555555555555555, 64'hFEDCBA9876543210};
      vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'h123456789ABCDEF0, 10,
                  stub_ref(64'hFFFFFFFFFFFFFFFF), 64'h123456789ABCDEF0};
      vecs[3] = '{64'h5555555555555555, 64'hA5A5A5A5A5A5A5A5, 3,
                  stub_ref(64'h5555555555555555), 64'hA5A5A5A5A5A5A5A5};

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_share0", out_share0, 64'h0);
      chk("rst_out_share1", out_share1, 64'h0);
      chk("rst_sbox_a", 64'({sbox_a0, sbox_a1}), 64'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         run_txn(vecs[i].s0, vecs[i].s1, vecs[i].hold, r0, r1, lat);
         chk("vec_share0", r0, vecs[i].e0);
         chk("vec_share1", r1, vecs[i].e1);
      end

      // Abort mid-run at cnt==7, then a clean transaction.
      @(negedge clk);
      in_valid = 1'b1; in_share0 = 64'hDEADBEEFCAFEF00D; in_share1 = 64'h1;
      @(posedge clk);
      repeat (7) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_abort_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_sbox_a", 64'({sbox_a0, sbox_a1}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(vecs[0].s0, vecs[0].s1, 0, r0, r1, lat);
      chk("post_abort_share0", r0, vecs[0].e0);
      chk("post_abort_share1", r1, vecs[0].e1);

      // Core left holding garbage across reset and into the accept edge.
      real_core = 1'b1;
      @(negedge clk);
      rst_n = 1'b0; poison = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      s = 64'h0123456789ABCDEF; m = 64'h9E3779B97F4A7C15;
      run_txn(s ^ m, m, 0, r0, r1, lat);
      chk("stale_core_result", r0 ^ r1, golden_inv(s));

      for (int t = 0; t < 1000; t++) begin
         s = {$urandom, $urandom};
         m = {$urandom, $urandom};
         run_txn(s ^ m, m, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                 r0, r1, lat);
         chk("random_inv_sbox", r0 ^ r1, golden_inv(s));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
